// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_access_pkg
// Brief  : Shared encodings for the load/store unit: access sizes, FSM states,
//          default RAM capacity and a size-to-byte-count helper.
// Rev    : 1.0  initial release
// ============================================================================
package mem_access_pkg;

    localparam int DEF_MEM_BYTES = 256;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Illegal size reports 4 bytes; it is rejected independently of range.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane.sv
`default_nettype none
// ============================================================================
// Module : byte_lane
// Brief  : Big-endian lane extract/extend for loads and lane merge for stores,
//          keyed by access size and the low two address bits.
// Rev    : 1.0  initial release
// ============================================================================
module byte_lane
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic [31:0] rword,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte at offset 0 lives in bits 31:24.
    always_comb begin
        w_byte = 8'h00;
        case (offset)
            2'd0:    w_byte = rword[31:24];
            2'd1:    w_byte = rword[23:16];
            2'd2:    w_byte = rword[15:8];
            default: w_byte = rword[7:0];
        endcase
        w_half = offset[1] ? rword[15:0] : rword[31:16];
    end

    always_comb begin
        load_data = rword;
        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: load_data = {{16{is_signed & w_half[15]}}, w_half};
            default:   load_data = rword;
        endcase
    end

    always_comb begin
        merge_data = rword;
        case (size)
            SIZE_BYTE: begin
                case (offset)
                    2'd0:    merge_data[31:24] = wdata[7:0];
                    2'd1:    merge_data[23:16] = wdata[7:0];
                    2'd2:    merge_data[15:8]  = wdata[7:0];
                    default: merge_data[7:0]   = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (offset[1]) begin
                    merge_data[15:0] = wdata;
                end else begin
                    merge_data[31:16] = wdata;
                end
            end
            default: merge_data = rword;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit
// Brief  : Single-outstanding load/store unit in front of a big-endian byte
//          RAM; sub-word stores are done as read-modify-write.
// Rev    : 1.0  initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] c_mem_limit = 33'(MEM_BYTES);

    state_t      r_state;
    state_t      w_next_state;

    logic        r_we;
    logic        r_signed;
    logic        r_err;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;
    logic [31:0] r_rdword;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_rw;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_req_err;
    logic [32:0] w_req_end;
    logic [31:0] w_lane_word;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_accept = req_valid & req_ready;

    // 33-bit end address so addresses near 2^32 cannot wrap into range.
    always_comb begin
        w_req_end    = {1'b0, req_addr} + {30'd0, size_bytes(req_size)};
        w_misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                       ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
        w_req_err    = (req_size == SIZE_ILLEGAL) || w_misaligned ||
                       (w_req_end > c_mem_limit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next_state = ST_RESP;
                    end else if (req_we && (req_size == SIZE_WORD)) begin
                        w_next_state = ST_WR;
                    end else begin
                        w_next_state = ST_RD;
                    end
                end
            end
            ST_RD:   w_next_state = r_we ? ST_WR : ST_RESP;
            ST_WR:   w_next_state = ST_RESP;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE) && rst_n;
        rsp_valid = (r_state == ST_RESP);
        rsp_err   = rsp_valid && r_err;
        rsp_rdata = 32'd0;
        if (rsp_valid && !r_err && !r_we) begin
            rsp_rdata = w_load_data;
        end
    end

    // RAM-side outputs are launched one edge ahead of the RD/WR cycle they
    // serve, so they sit stable across the falling write edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
            r_err       <= 1'b0;
            r_size      <= SIZE_BYTE;
            r_off       <= 2'b00;
            r_wdata     <= 16'd0;
            r_rdword    <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_rw    <= 1'b0;
        end else begin
            r_mem_rw <= 1'b0;
            if (w_accept) begin
                r_we     <= req_we;
                r_signed <= req_signed;
                r_err    <= w_req_err;
                r_size   <= req_size;
                r_off    <= req_addr[1:0];
                r_wdata  <= req_wdata[15:0];
                if (!w_req_err) begin
                    r_mem_addr <= {req_addr[31:2], 2'b00};
                    if (req_we && (req_size == SIZE_WORD)) begin
                        r_mem_wdata <= req_wdata;
                        r_mem_rw    <= 1'b1;
                    end
                end
            end
            if (r_state == ST_RD) begin
                r_rdword <= mem_rdata;
                if (r_we) begin
                    r_mem_wdata <= w_merge_data;
                    r_mem_rw    <= 1'b1;
                end
            end
        end
    end

    // Merge works on the live RAM word during RD; loads use the captured copy.
    assign w_lane_word = (r_state == ST_RD) ? mem_rdata : r_rdword;

    byte_lane u_byte_lane (
        .size       (r_size),
        .offset     (r_off),
        .is_signed  (r_signed),
        .rword      (w_lane_word),
        .wdata      (r_wdata),
        .load_data  (w_load_data),
        .merge_data (w_merge_data)
    );

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_rw    = r_mem_rw;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Self-checking bench: directed vector table, reset abort sequence
//          and random traffic against a byte-array reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    logic [7:0]  ram     [0:255];
    logic [7:0]  ref_mem [0:255];
    int          wr_count = 0;
    logic [31:0] last_wdata = 32'd0;
    logic [31:0] last_waddr = 32'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_unit #(.MEM_BYTES(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rw     (mem_rw),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        logic [7:0] v;
        case (i)
            0: v = 8'h12;
            1: v = 8'h34;
            2: v = 8'h56;
            3: v = 8'h78;
            default: v = 8'((i * 37 + 5) & 255);
        endcase
        return v;
    endfunction

    // Behavioural RAM: combinational big-endian read, falling-edge write.
    always_comb begin
        logic [7:0] b;
        b = mem_addr[7:0];
        mem_rdata = {ram[b], ram[b + 8'd1], ram[b + 8'd2], ram[b + 8'd3]};
    end

    initial begin
        logic [7:0] b;
        for (int i = 0; i < 256; i++) ram[i] = init_byte(i);
        forever begin
            @(negedge clk);
            if (mem_rw) begin
                b = mem_addr[7:0];
                ram[b]        = mem_wdata[31:24];
                ram[b + 8'd1] = mem_wdata[23:16];
                ram[b + 8'd2] = mem_wdata[15:8];
                ram[b + 8'd3] = mem_wdata[7:0];
                wr_count   = wr_count + 1;
                last_wdata = mem_wdata;
                last_waddr = mem_addr;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model straight from the access rules, on a byte array.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int wrs, output logic [31:0] wword);
        int     nb;
        int     a;
        int     base;
        longint val;
        nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err   = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                (size == 2'd2 && addr[1:0] != 2'b00) ||
                (longint'({32'd0, addr}) + nb > 256);
        rdata = 32'd0;
        wrs   = 0;
        wword = 32'd0;
        if (err) begin
            lat = 1;
        end else begin
            a = int'(addr);
            if (!we) begin
                val = 0;
                for (int i = 0; i < nb; i++) val = val * 256 + longint'(ref_mem[a + i]);
                if (sgn && nb < 4 && val >= (longint'(1) << (8 * nb - 1)))
                    val = val - (longint'(1) << (8 * nb));
                rdata = val[31:0];
                lat   = 2;
            end else begin
                for (int i = 0; i < nb; i++)
                    ref_mem[a + i] = 8'((wdata >> (8 * (nb - 1 - i))) & 32'hFF);
                base  = a - (a % 4);
                wword = {ref_mem[base], ref_mem[base + 1], ref_mem[base + 2], ref_mem[base + 3]};
                wrs   = 1;
                lat   = (nb == 4) ? 2 : 3;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int wrs, output logic [31:0] wword, output logic [31:0] waddr);
        int guard;
        int wr_base;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got req_ready=0, expected 1 within 10 cycles");
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wr_base   = wr_count;
        lat       = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) lat = 99;
        rdata = rsp_rdata;
        err   = rsp_err;
        wrs   = wr_count - wr_base;
        wword = last_wdata;
        waddr = last_waddr;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_wword;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input int exp_wr, input logic [31:0] exp_wword);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_wr = exp_wr; v.exp_wword = exp_wword;
        return v;
    endfunction

    initial begin
        vec_t        vt [20];
        logic [31:0] g_rdata, g_wword, g_waddr, m_rdata, m_wword;
        logic        g_err, m_err;
        int          g_lat, g_wrs, m_lat, m_wrs, bad;
        logic        r_we, r_sgn;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wdata;
        string       tag;

        vt[0]  = mk(0, 2'd2, 0, 32'd0,   32'h0,        32'h12345678, 0, 2, 0, 32'h0);
        vt[1]  = mk(0, 2'd0, 1, 32'd2,   32'h0,        32'h00000056, 0, 2, 0, 32'h0);
        vt[2]  = mk(0, 2'd0, 0, 32'd2,   32'h0,        32'h00000056, 0, 2, 0, 32'h0);
        vt[3]  = mk(1, 2'd1, 0, 32'd2,   32'h0000BEEF, 32'h0,        0, 3, 1, 32'h1234BEEF);
        vt[4]  = mk(0, 2'd2, 0, 32'd0,   32'h0,        32'h1234BEEF, 0, 2, 0, 32'h0);
        vt[5]  = mk(1, 2'd0, 0, 32'd3,   32'h0000009A, 32'h0,        0, 3, 1, 32'h1234BE9A);
        vt[6]  = mk(0, 2'd0, 1, 32'd3,   32'h0,        32'hFFFFFF9A, 0, 2, 0, 32'h0);
        vt[7]  = mk(0, 2'd0, 0, 32'd3,   32'h0,        32'h0000009A, 0, 2, 0, 32'h0);
        vt[8]  = mk(0, 2'd1, 1, 32'd2,   32'h0,        32'hFFFFBE9A, 0, 2, 0, 32'h0);
        vt[9]  = mk(0, 2'd1, 0, 32'd2,   32'h0,        32'h0000BE9A, 0, 2, 0, 32'h0);
        vt[10] = mk(0, 2'd2, 0, 32'd6,   32'h0,        32'h0,        1, 1, 0, 32'h0);
        vt[11] = mk(0, 2'd3, 0, 32'd0,   32'h0,        32'h0,        1, 1, 0, 32'h0);
        vt[12] = mk(1, 2'd2, 0, 32'd252, 32'hCAFEF00D, 32'h0,        0, 2, 1, 32'hCAFEF00D);
        vt[13] = mk(0, 2'd2, 0, 32'd252, 32'h0,        32'hCAFEF00D, 0, 2, 0, 32'h0);
        vt[14] = mk(0, 2'd2, 0, 32'd254, 32'h0,        32'h0,        1, 1, 0, 32'h0);
        vt[15] = mk(0, 2'd1, 0, 32'd255, 32'h0,        32'h0,        1, 1, 0, 32'h0);
        vt[16] = mk(0, 2'd1, 1, 32'd254, 32'h0,        32'hFFFFF00D, 0, 2, 0, 32'h0);
        vt[17] = mk(0, 2'd0, 0, 32'd256, 32'h0,        32'h0,        1, 1, 0, 32'h0);
        vt[18] = mk(1, 2'd3, 0, 32'd8,   32'h11223344, 32'h0,        1, 1, 0, 32'h0);
        vt[19] = mk(0, 2'd0, 0, 32'd255, 32'h0,        32'h0000000D, 0, 2, 0, 32'h0);

        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("reset_rsp_rdata", rsp_rdata,          32'd0);
        check("reset_mem_rw",    {31'd0, mem_rw},    32'd0);
        check("reset_mem_addr",  mem_addr,           32'd0);
        check("reset_mem_wdata", mem_wdata,          32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            do_req(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata,
                   g_rdata, g_err, g_lat, g_wrs, g_wword, g_waddr);
            model(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata,
                  m_rdata, m_err, m_lat, m_wrs, m_wword);
            check($sformatf("vec%0d_rdata", i), g_rdata, vt[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, g_err}, {31'd0, vt[i].exp_err});
            check($sformatf("vec%0d_latency", i), g_lat, vt[i].exp_lat);
            check($sformatf("vec%0d_writes", i), g_wrs, vt[i].exp_wr);
            if (vt[i].exp_wr != 0) begin
                check($sformatf("vec%0d_wdata", i), g_wword, vt[i].exp_wword);
                check($sformatf("vec%0d_waddr", i), g_waddr, vt[i].addr & 32'hFFFF_FFFC);
            end
        end

        // Reset while a sub-word store is in its read phase.
        tag = "rst_abort";
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'd16; req_wdata = 32'h000000A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        bad = wr_count;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_mem_rw"},    {31'd0, mem_rw},    32'd0);
        check({tag, "_mem_addr"},  mem_addr,           32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,          32'd0);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_no_rsp"},    {31'd0, rsp_valid}, 32'd0);
        check({tag, "_no_write"},  wr_count - bad,     32'd0);
        check({tag, "_ram16"},     {24'd0, ram[16]},   {24'd0, ref_mem[16]});

        for (int n = 0; n < 200; n++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_sgn   = 1'($urandom_range(0, 1));
            r_addr  = $urandom_range(0, 259);
            r_wdata = $urandom;
            do_req(r_we, r_size, r_sgn, r_addr, r_wdata,
                   g_rdata, g_err, g_lat, g_wrs, g_wword, g_waddr);
            model(r_we, r_size, r_sgn, r_addr, r_wdata,
                  m_rdata, m_err, m_lat, m_wrs, m_wword);
            check($sformatf("rnd%0d_rdata", n),   g_rdata, m_rdata);
            check($sformatf("rnd%0d_err", n),     {31'd0, g_err}, {31'd0, m_err});
            check($sformatf("rnd%0d_latency", n), g_lat, m_lat);
            check($sformatf("rnd%0d_writes", n),  g_wrs, m_wrs);
            if (m_wrs != 0) begin
                check($sformatf("rnd%0d_wdata", n), g_wword, m_wword);
                check($sformatf("rnd%0d_waddr", n), g_waddr, r_addr & 32'hFFFF_FFFC);
            end
        end

        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
        check("ram_image_bytes_differing", bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The parameter SHALL be MEM_BYTES, default 256, giving the byte capacity of the attached data RAM.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit: reset, synchronous and active-low.
REQ-004 Port req_valid SHALL be an input, 1 bit: load/store request present.
REQ-005 Port req_ready SHALL be an output, 1 bit: unit accepts a request this cycle.
REQ-006 Port req_we SHALL be an input, 1 bit: 1 = store, 0 = load.
REQ-007 Port req_size SHALL be an input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 Port req_signed SHALL be an input, 1 bit: sign-extend sub-word loads.
REQ-009 Port req_addr SHALL be an input, 32 bits: byte address.
REQ-010 Port req_wdata SHALL be an input, 32 bits: store data, right-justified for sub-word stores.
REQ-011 Port rsp_valid SHALL be an output, 1 bit: one-cycle completion pulse.
REQ-012 Port rsp_rdata SHALL be an output, 32 bits: load result; 0 for stores and errors.
REQ-013 Port rsp_err SHALL be an output, 1 bit: misaligned, illegal-size or out-of-range request.
REQ-014 Ports mem_addr (output, 32 bits), mem_wdata (output, 32 bits), mem_rw (output, 1 bit, 1 = write) and mem_rdata (input, 32 bits) SHALL drive the data RAM.

Function
REQ-015 The RAM contract SHALL be: big-endian, byte addr+0 maps to bits 31:24; the read is combinational while mem_rw=0; the write commits on the falling clk edge while mem_rw=1.
REQ-016 The FSM states SHALL be IDLE, RD, WR, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both 1, with all req_* fields registered on that edge.
REQ-018 A request SHALL be flagged as an error on acceptance if req_size=11, or half with addr[0]=1, or word with addr[1:0]!=0, or addr+bytes>MEM_BYTES.
REQ-019 An error request SHALL go IDLE->RESP with no RAM cycle: mem_rw stays 0, rsp_err=1, rsp_rdata=0.
REQ-020 Word load SHALL follow IDLE->RD->RESP: in RD, mem_addr={addr[31:2],2'b00} and mem_rw=0; mem_rdata is sampled at the end of RD.
REQ-021 Byte/half load SHALL follow the same path; the lane is extracted big-endian by addr[1:0] and sign-extended if req_signed, else zero-extended.
REQ-022 Word store SHALL follow IDLE->WR->RESP: in WR, mem_rw=1 for exactly one cycle, mem_wdata=req_wdata, and the address is word-aligned.
REQ-023 Byte/half store SHALL follow IDLE->RD->WR->RESP as a read-modify-write: the RD word is captured and only the addressed lane(s) are replaced with req_wdata[7:0] or [15:0].
REQ-024 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE; a new request can be accepted in the cycle after RESP.
REQ-025 Latency from acceptance edge to rsp_valid SHALL be: error 1, word or sub-word load 2, word store 2, sub-word store 3 cycles.
REQ-026 Outside RD/WR, mem_rw SHALL be 0, and mem_addr and mem_wdata SHALL hold their last values.
REQ-027 mem_rw, mem_addr and mem_wdata SHALL be registered, never combinational from req_*, so they are stable across the falling edge.
REQ-028 rsp_rdata and rsp_err SHALL be valid only while rsp_valid=1 and SHALL be 0 otherwise.

Reset
REQ-029 When rst_n=0 at a rising edge, the unit SHALL enter IDLE with mem_rw=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-030 Reset mid-operation SHALL abort without a response; a WR-cycle falling edge that precedes the reset edge still writes, and this is accepted behaviour.
REQ-031 req_ready SHALL be 0 while rst_n=0.

Structure
REQ-032 Package mem_access_pkg SHALL hold the size encodings, the FSM state enum and the default MEM_BYTES.
REQ-033 The combinational sub-module byte_lane SHALL perform lane extract/extend for loads and lane merge for stores, keyed by size and addr[1:0].

Verification
REQ-034 RAM[0..3]=12 34 56 78; word load addr 0 -> rsp_valid 2 cycles after accept, rdata=0x12345678, err=0.
REQ-035 Same RAM; byte load addr 2, signed and unsigned; RAM[3]=0x9A -> addr 3 signed gives 0xFFFFFF9A, unsigned gives 0x0000009A.
REQ-036 Half store 0xBEEF at addr 2 over 0x12345678 -> exactly one mem_rw=1 cycle with mem_wdata=0x1234BEEF, rsp at 3 cycles.
REQ-037 Word load addr 0x06 and size=11 -> rsp_err=1 after 1 cycle, mem_rw never 1.
REQ-038 Word store addr 252 succeeds; word load addr 254 (half at 255) -> rsp_err=1 per range/alignment rules.
REQ-039 rst_n low during RD of a sub-word store -> no write, no rsp_valid, IDLE next cycle, outputs at reset values.
